// File: rtl/qbus_dma_arb_if.sv
// Signal bundle between the local DMA arbiter and its requesters / Q-bus side.
// The master modport is the arbiter's view; slave is the environment's view.
interface qbus_dma_arb_if;
    logic [1:0] n_req;
    logic [1:0] n_sack_loc;
    logic [1:0] n_gnt;
    logic [1:0] owner;
    logic       n_dmr;
    logic       n_dmgi;
    logic       n_dmgo;
    logic       n_sack;
    logic       n_sync;
    logic       n_bsy;
    logic       tout_p;

    modport master (
        input  n_req, n_sack_loc, n_dmgi, n_sync, n_bsy,
        output n_gnt, n_dmr, n_dmgo, n_sack, owner, tout_p
    );

    modport slave (
        output n_req, n_sack_loc, n_dmgi, n_sync, n_bsy,
        input  n_gnt, n_dmr, n_dmgo, n_sack, owner, tout_p
    );
endinterface

// File: rtl/qbus_dma_arb.sv
// Local DMA arbiter: shares one Q-bus DMR/DMG slot between two local requesters
// with round-robin selection, daisy-chain pass-through and grant timeout.
module qbus_dma_arb #(
    parameter int TOUT = 64,
    parameter int TW   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    qbus_dma_arb_if.master    bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_GRANT   = 3'd2;
    localparam logic [2:0] S_OWN     = 3'd3;
    localparam logic [2:0] S_PASS    = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    localparam logic [TW-1:0] TOUT_CNT = TW'(TOUT);

    logic [1:0]    req_m, req_s;
    logic          dmgi_m, dmgi_s;
    logic          sync_m, sync_s;
    logic          bsy_m, bsy_s;

    logic [2:0]    state, state_nx;
    logic          sel, sel_nx;
    logic          last, last_nx;
    logic [TW-1:0] cnt, cnt_nx;
    logic          to_hit, to_nx;
    logic          pick;

    logic [1:0]    gnt_q;
    logic [1:0]    owner_q;
    logic          dmr_q, dmgo_q, sack_q, tout_q;

    // Two-flop synchronizers; idle level is high for every active-low input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_m  <= '1;
            req_s  <= '1;
            dmgi_m <= 1'b1;
            dmgi_s <= 1'b1;
            sync_m <= 1'b1;
            sync_s <= 1'b1;
            bsy_m  <= 1'b1;
            bsy_s  <= 1'b1;
        end else begin
            req_m  <= bus.n_req;
            req_s  <= req_m;
            dmgi_m <= bus.n_dmgi;
            dmgi_s <= dmgi_m;
            sync_m <= bus.n_sync;
            sync_s <= sync_m;
            bsy_m  <= bus.n_bsy;
            bsy_s  <= bsy_m;
        end
    end

    // Lone requester wins; on a tie the one that did not own the bus last wins.
    always_comb begin
        if (req_s == 2'b00) pick = ~last;
        else                pick = req_s[0];
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        last_nx  = last;
        cnt_nx   = cnt;
        to_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!dmgi_s) begin
                    state_nx = S_PASS;
                end else if (req_s != 2'b11) begin
                    sel_nx   = pick;
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                if (!dmgi_s) begin
                    if (!req_s[sel]) begin
                        cnt_nx   = '0;
                        state_nx = S_GRANT;
                    end else begin
                        state_nx = S_PASS;
                    end
                end
            end
            S_GRANT: begin
                cnt_nx = cnt + 1'b1;
                if (!bus.n_sack_loc[sel]) begin
                    state_nx = S_OWN;
                end else if (cnt == TOUT_CNT) begin
                    to_nx    = 1'b1;
                    state_nx = S_RELEASE;
                end
            end
            S_OWN: begin
                if (bus.n_sack_loc[sel]) begin
                    last_nx  = sel;
                    state_nx = S_RELEASE;
                end
            end
            S_PASS: begin
                if (dmgi_s) state_nx = S_IDLE;
            end
            S_RELEASE: begin
                if (dmgi_s && sync_s && bsy_s) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            sel    <= 1'b0;
            last   <= 1'b1;
            cnt    <= '0;
            to_hit <= 1'b0;
        end else begin
            state  <= state_nx;
            sel    <= sel_nx;
            last   <= last_nx;
            cnt    <= cnt_nx;
            to_hit <= to_nx;
        end
    end

    // Outputs are a registered decode of the current state, one edge behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q   <= '1;
            dmr_q   <= 1'b1;
            dmgo_q  <= 1'b1;
            sack_q  <= 1'b1;
            owner_q <= '0;
            tout_q  <= 1'b0;
        end else begin
            gnt_q   <= '1;
            dmr_q   <= 1'b1;
            dmgo_q  <= 1'b1;
            sack_q  <= 1'b1;
            owner_q <= '0;
            tout_q  <= to_hit;
            case (state)
                S_REQ: dmr_q <= 1'b0;
                S_GRANT: begin
                    dmr_q      <= 1'b0;
                    gnt_q[sel] <= 1'b0;
                end
                S_OWN: begin
                    sack_q       <= 1'b0;
                    owner_q[sel] <= 1'b1;
                end
                S_PASS: dmgo_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.n_gnt  = gnt_q;
    assign bus.n_dmr  = dmr_q;
    assign bus.n_dmgo = dmgo_q;
    assign bus.n_sack = sack_q;
    assign bus.owner  = owner_q;
    assign bus.tout_p = tout_q;

endmodule

// File: tb/tb_qbus_dma_arb.sv
// Self-checking bench for qbus_dma_arb: per-scenario tasks push expected output
// snapshots keyed by cycle and compare them as the cycles are reached.
module tb_qbus_dma_arb;

    localparam int TOUT_TB = 16;

    // {n_gnt[1:0], n_dmr, n_dmgo, n_sack, owner[1:0], tout_p}
    localparam logic [7:0] IDLE_O = 8'b11_1_1_1_00_0;
    localparam logic [7:0] REQ_O  = 8'b11_0_1_1_00_0;
    localparam logic [7:0] GNT0   = 8'b10_0_1_1_00_0;
    localparam logic [7:0] GNT1   = 8'b01_0_1_1_00_0;
    localparam logic [7:0] OWN0   = 8'b11_1_1_0_01_0;
    localparam logic [7:0] OWN1   = 8'b11_1_1_0_10_0;
    localparam logic [7:0] PASS_O = 8'b11_1_0_1_00_0;
    localparam logic [7:0] TO_O   = 8'b11_1_1_1_00_1;

    typedef struct {
        int         cyc;
        logic [7:0] val;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    qbus_dma_arb_if bus();

    qbus_dma_arb #(.TOUT(TOUT_TB), .TW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {bus.n_gnt, bus.n_dmr, bus.n_dmgo, bus.n_sack, bus.owner, bus.tout_p};
    endfunction

    function automatic void push_exp(int cyc, logic [7:0] v, string tag);
        exp_t e;
        e.cyc = cyc;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.n_req      = 2'b11;
        bus.n_sack_loc = 2'b11;
        bus.n_dmgi     = 1'b1;
        bus.n_sync     = 1'b1;
        bus.n_bsy      = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (outs() !== IDLE_O) begin
            errors++;
            $display("FAIL rst_hold got=%b exp=%b", outs(), IDLE_O);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (outs() !== IDLE_O) begin
            errors++;
            $display("FAIL rst_idle got=%b exp=%b", outs(), IDLE_O);
        end
    endtask

    task automatic test_single();
        exp_t e;
        bus.n_req = 2'b10;
        push_exp(3,  IDLE_O, "single_dmr_pre");
        push_exp(4,  REQ_O,  "single_dmr_lat");
        push_exp(7,  REQ_O,  "single_gnt_pre");
        push_exp(8,  GNT0,   "single_gnt_lat");
        push_exp(13, GNT0,   "single_gnt_hold");
        push_exp(14, GNT0,   "single_sack_pre");
        push_exp(15, OWN0,   "single_sack_lat");
        push_exp(19, OWN0,   "single_rel_pre");
        push_exp(20, IDLE_O, "single_rel_lat");
        push_exp(24, IDLE_O, "single_idle");
        for (int c = 1; c <= 24; c++) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (outs() !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, c, outs(), e.val);
                end
            end
            case (c)
                4:  bus.n_dmgi = 1'b0;
                13: bus.n_sack_loc = 2'b10;
                15: bus.n_dmgi = 1'b1;
                18: begin bus.n_sack_loc = 2'b11; bus.n_req = 2'b11; end
                default: ;
            endcase
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        do_reset();
        bus.n_req = 2'b00;
        push_exp(4,  REQ_O,  "rr_dmr");
        push_exp(8,  GNT0,   "rr_first_gnt0");
        push_exp(10, OWN0,   "rr_first_own0");
        push_exp(14, IDLE_O, "rr_first_done");
        push_exp(15, IDLE_O, "rr_b2b_pre");
        push_exp(16, REQ_O,  "rr_b2b_dmr");
        push_exp(19, REQ_O,  "rr_second_pre");
        push_exp(20, GNT1,   "rr_second_gnt1");
        push_exp(22, OWN1,   "rr_second_own1");
        push_exp(25, OWN1,   "rr_second_hold");
        push_exp(26, IDLE_O, "rr_second_done");
        push_exp(28, IDLE_O, "rr_idle");
        for (int c = 1; c <= 28; c++) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (outs() !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, c, outs(), e.val);
                end
            end
            case (c)
                4:  bus.n_dmgi = 1'b0;
                8:  bus.n_sack_loc = 2'b10;
                10: bus.n_dmgi = 1'b1;
                12: begin bus.n_sack_loc = 2'b11; bus.n_req = 2'b01; end
                16: bus.n_dmgi = 1'b0;
                20: bus.n_sack_loc = 2'b01;
                22: bus.n_dmgi = 1'b1;
                24: begin bus.n_sack_loc = 2'b11; bus.n_req = 2'b11; end
                default: ;
            endcase
        end
    endtask

    task automatic test_foreign();
        exp_t e;
        bus.n_dmgi = 1'b0;
        push_exp(3,  IDLE_O, "fgn_pre");
        push_exp(4,  PASS_O, "fgn_dmgo_lat");
        push_exp(7,  PASS_O, "fgn_hold_a");
        push_exp(10, PASS_O, "fgn_hold_b");
        push_exp(13, PASS_O, "fgn_rel_pre");
        push_exp(14, IDLE_O, "fgn_rel");
        for (int c = 1; c <= 14; c++) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (outs() !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, c, outs(), e.val);
                end
            end
            if (c == 10) bus.n_dmgi = 1'b1;
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        bus.n_req = 2'b10;
        push_exp(4,            REQ_O,  "to_dmr");
        push_exp(8,            GNT0,   "to_gnt");
        push_exp(TOUT_TB + 8,  GNT0,   "to_pre");
        push_exp(TOUT_TB + 9,  TO_O,   "to_pulse");
        push_exp(TOUT_TB + 10, IDLE_O, "to_once");
        push_exp(TOUT_TB + 16, IDLE_O, "to_idle");
        for (int c = 1; c <= TOUT_TB + 16; c++) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (outs() !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, c, outs(), e.val);
                end
            end
            if (c == 4) bus.n_dmgi = 1'b0;
            if (c == TOUT_TB + 10) begin
                bus.n_dmgi = 1'b1;
                bus.n_req  = 2'b11;
            end
        end
    endtask

    task automatic test_withdraw();
        exp_t e;
        bus.n_req = 2'b10;
        push_exp(4,  REQ_O,  "wd_dmr");
        push_exp(9,  REQ_O,  "wd_pre");
        push_exp(10, PASS_O, "wd_pass");
        push_exp(15, PASS_O, "wd_hold");
        push_exp(16, IDLE_O, "wd_idle");
        for (int c = 1; c <= 16; c++) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (outs() !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, c, outs(), e.val);
                end
            end
            case (c)
                4:  bus.n_req = 2'b11;
                6:  bus.n_dmgi = 1'b0;
                12: bus.n_dmgi = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid_own();
        exp_t e;
        bus.n_req = 2'b01;
        push_exp(4,  REQ_O, "mid_dmr");
        push_exp(8,  GNT1,  "mid_gnt1");
        push_exp(10, OWN1,  "mid_own1");
        for (int c = 1; c <= 10; c++) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (outs() !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, c, outs(), e.val);
                end
            end
            if (c == 4) bus.n_dmgi = 1'b0;
            if (c == 8) bus.n_sack_loc = 2'b01;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== IDLE_O) begin
            errors++;
            $display("FAIL mid_rst_async got=%b exp=%b", outs(), IDLE_O);
        end
        idle_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        // Tied requests after reset must go to requester 0 from an idle FSM.
        bus.n_req = 2'b00;
        push_exp(1, IDLE_O, "post_rst_idle");
        push_exp(4, REQ_O,  "post_rst_dmr");
        push_exp(8, GNT0,   "post_rst_gnt0");
        for (int c = 1; c <= 8; c++) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                checks++;
                if (outs() !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b", e.tag, c, outs(), e.val);
                end
            end
            if (c == 4) bus.n_dmgi = 1'b0;
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_simultaneous();
        test_foreign();
        test_timeout();
        test_withdraw();
        test_reset_mid_own();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drained got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
